stream_to_axi_w: RTL

Decoder for the AXI write-data tap stream: consumes the packed stream produced on the W-channel side (metadata word, data words, packed strobe word) and replays it as an AXI write-data burst on an AXI master W interface. It sits at the receiving end of the Ethernet link, between the stream demultiplexer and the AXI interconnect. Strobes arrive after the data, so the block buffers one full burst before replaying it.

---
 rtl/stream_axi_pkg.sv | 22 ++
 rtl/w_burst_buffer.sv | 37 +++
 rtl/stream_to_axi_w.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/stream_axi_pkg.sv
// Shared types and field helpers for the AXI write-data stream decoder.
// The tag offset and strobe slot width depend on DATA_WIDTH, so they are functions.
package stream_axi_pkg;

    typedef enum logic [1:0] {
        META   = 2'd0,
        DATA   = 2'd1,
        REPLAY = 2'd2,
        DROP   = 2'd3
    } state_e;

    // LSB of the type tag, which sits in the top bits of every stream word.
    function automatic int tag_lsb(input int data_width, input int tag_width);
        return data_width - tag_width;
    endfunction

    // Bytes per beat, i.e. width of one strobe slot.
    function automatic int strb_slot_w(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/w_burst_buffer.sv
// BURST_SIZE x DATA_WIDTH register file that holds one burst until its strobes arrive.
// A single write port, a single combinational read port and a synchronous clear.
module w_burst_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the storage is reset and cleared like ordinary flops, so it maps to
    // registers rather than a RAM macro; acceptable at a depth of a few beats.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else if (clr_i) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else if (wr_en_i && (wr_idx_i < DEPTH_IDX)) begin
            mem_q[wr_idx_i[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = (rd_idx_i < DEPTH_IDX) ? mem_q[rd_idx_i[AW-1:0]] : '0;

endmodule

// File: rtl/stream_to_axi_w.sv
// Decodes a packed W-channel tap stream (metadata, data words, strobe word) and
// replays it as an AXI write-data burst once the trailing strobe word has arrived.
module stream_to_axi_w
    import stream_axi_pkg::*;
#(
    parameter int                           DATA_WIDTH        = 128,
    parameter int                           ID_WIDTH          = 32,
    parameter int                           USER_WIDTH        = 64,
    parameter int                           STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = 3'b011,
    parameter int                           BURST_SIZE        = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_last,
    output logic [ID_WIDTH-1:0]     AXIM_wid,
    output logic [DATA_WIDTH-1:0]   AXIM_wdata,
    output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
    output logic                    AXIM_wlast,
    output logic [USER_WIDTH-1:0]   AXIM_wuser,
    output logic                    AXIM_wvalid,
    input  logic                    AXIM_wready,
    output logic                    err_type,
    output logic                    err_len
);

    localparam int SW      = strb_slot_w(DATA_WIDTH);
    localparam int TAG_LSB = tag_lsb(DATA_WIDTH, STREAM_TYPE_WIDTH);
    localparam int F_W     = BURST_SIZE * SW;
    localparam int CW      = $clog2(BURST_SIZE + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(BURST_SIZE);

    state_e              state_q, state_d;
    logic [CW-1:0]       n_q, n_d;
    logic [CW-1:0]       i_q, i_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [F_W-1:0]      strb_q, strb_d;
    logic                ovf_q, ovf_d;
    logic                err_type_q, err_type_d;
    logic                err_len_q, err_len_d;

    logic                   buf_wr_en;
    logic                   buf_clr;
    logic [DATA_WIDTH-1:0]  buf_rd_data;
    logic                   s_accept;
    logic                   replay;
    logic                   beat_last;
    logic [CW-1:0]          slot;
    logic [F_W-1:0]         strb_shift;
    logic [STREAM_TYPE_WIDTH-1:0] tag;

    assign tag       = s_data[TAG_LSB +: STREAM_TYPE_WIDTH];
    assign replay    = (state_q == REPLAY);
    assign s_ready   = resetn && !replay;
    assign s_accept  = s_valid && s_ready;
    assign beat_last = (i_q == n_q - CW'(1));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        i_d        = i_q;
        id_d       = id_q;
        strb_d     = strb_q;
        ovf_d      = ovf_q;
        err_type_d = 1'b0;
        err_len_d  = 1'b0;
        buf_wr_en  = 1'b0;
        buf_clr    = 1'b0;

        unique case (state_q)
            META: begin
                if (s_accept) begin
                    if (tag == STREAM_TYPE) begin
                        id_d    = s_data[ID_WIDTH-1:0];
                        n_d     = '0;
                        ovf_d   = 1'b0;
                        state_d = DATA;
                    end else begin
                        err_type_d = 1'b1;
                        if (!s_last) state_d = DROP;
                    end
                end
            end
            DATA: begin
                if (s_accept && !s_last) begin
                    if (n_q < BURST_MAX) begin
                        buf_wr_en = 1'b1;
                        n_d       = n_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (s_accept) begin
                    if (ovf_q || (n_q == '0)) begin
                        err_len_d = 1'b1;
                        n_d       = '0;
                        ovf_d     = 1'b0;
                        buf_clr   = 1'b1;
                        state_d   = META;
                    end else begin
                        strb_d  = s_data[F_W-1:0];
                        i_d     = '0;
                        state_d = REPLAY;
                    end
                end
            end
            REPLAY: begin
                if (AXIM_wready) begin
                    if (beat_last) begin
                        i_d     = '0;
                        state_d = META;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end
            end
            DROP: begin
                if (s_accept && s_last) state_d = META;
            end
            default: state_d = META;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= META;
            n_q        <= '0;
            i_q        <= '0;
            id_q       <= '0;
            strb_q     <= '0;
            ovf_q      <= 1'b0;
            err_type_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            i_q        <= i_d;
            id_q       <= id_d;
            strb_q     <= strb_d;
            ovf_q      <= ovf_d;
            err_type_q <= err_type_d;
            err_len_q  <= err_len_d;
        end
    end

    w_burst_buffer #(
        .DEPTH (BURST_SIZE),
        .WIDTH (DATA_WIDTH),
        .IDX_W (CW)
    ) u_buffer (
        .clk       (clk),
        .resetn    (resetn),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr_en),
        .wr_idx_i  (n_q),
        .wr_data_i (s_data),
        .rd_idx_i  (i_q),
        .rd_data_o (buf_rd_data)
    );

    // The last beat owns the least-significant strobe slot, the first beat the highest used one.
    assign slot       = n_q - CW'(1) - i_q;
    assign strb_shift = strb_q >> (32'(slot) * SW);

    assign AXIM_wvalid = replay;
    assign AXIM_wdata  = replay ? buf_rd_data : '0;
    assign AXIM_wstrb  = replay ? strb_shift[SW-1:0] : '0;
    assign AXIM_wlast  = replay && beat_last;
    assign AXIM_wid    = replay ? id_q : '0;
    assign AXIM_wuser  = '0;
    assign err_type    = err_type_q;
    assign err_len     = err_len_q;

endmodule
